// File: rtl/cpu_rotate_seq.sv
// Multi-step rotate sequencer: drives the external one-bit rotator once per clock
// so an 8-bit accumulator/carry pair is rotated 1..2**CNT_W positions.
module cpu_rotate_seq #(
  parameter int CNT_W = 3
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             START_I,
  input  logic [1:0]       OP_I,
  input  logic [CNT_W-1:0] CNT_I,
  input  logic [7:0]       A_I,
  input  logic             C_I,
  output logic [7:0]       ROT_X_O,
  output logic             ROT_C_O,
  output logic [1:0]       ROT_OP_O,
  input  logic [7:0]       ROT_E_I,
  input  logic             ROT_C_I,
  output logic [7:0]       A_O,
  output logic             C_O,
  output logic             BUSY_O,
  output logic             DONE_O
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_load;

  // A zero count request means the full 2**CNT_W steps; the extra MSB keeps it from wrapping.
  assign cnt_load = (CNT_I == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, CNT_I};

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      cy_q    <= 1'b0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    BUSY_O  = 1'b0;
    DONE_O  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        DONE_O = (state_q == S_DONE);
        if (START_I) begin
          acc_d   = A_I;
          cy_d    = C_I;
          op_d    = OP_I;
          cnt_d   = cnt_load;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        BUSY_O = 1'b1;
        acc_d  = ROT_E_I;
        cy_d   = ROT_C_I;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{CNT_W{1'b0}}, 1'b1}) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ROT_X_O  = acc_q;
  assign ROT_C_O  = cy_q;
  assign ROT_OP_O = op_q;
  assign A_O      = acc_q;
  assign C_O      = cy_q;

endmodule

// File: doc/cpu_rotate_seq.md
Name: cpu_rotate_seq

Overview:
Multi-step rotate sequencer for the 8008 CPU core. It drives the existing single-bit combinational rotator one step per clock, so an 8-bit operand can be rotated N positions (1..8). The sequencer holds the working accumulator/carry pair, feeds it to the rotator each cycle, and captures the rotator result. It sits between the instruction control unit (START/DONE handshake) and the rotator datapath.

Parameters:
CNT_W, 3, width of the step-count input; CNT_I=0 encodes 2**CNT_W steps (default 8).

Ports:
CLK_I  input  1  system clock, rising edge
RSTN_I  input  1  reset, asynchronous, active-low
START_I  input  1  request a rotate; sampled only while BUSY_O=0
OP_I  input  2  rotate type: 00 RLC, 01 RRC, 10 RAL, 11 RAR
CNT_I  input  CNT_W  step count; 0 means 2**CNT_W
A_I  input  8  operand accumulator
C_I  input  1  operand carry
ROT_X_O  output  8  to rotator X_I; equals working accumulator register
ROT_C_O  output  1  to rotator C_I; equals working carry register
ROT_OP_O  output  2  to rotator OP_I; latched OP
ROT_E_I  input  8  rotator E_O result
ROT_C_I  input  1  rotator C_O result
A_O  output  8  result accumulator (working register)
C_O  output  1  result carry (working register)
BUSY_O  output  1  high while stepping
DONE_O  output  1  one-cycle pulse: A_O/C_O final

Behaviour:
- Single clock CLK_I; reset is asynchronous and active-low (RSTN_I).
- Reset values: state=IDLE, A_O=8'h00, C_O=0, ROT_OP_O=2'b00, step counter=0, BUSY_O=0, DONE_O=0. ROT_X_O/ROT_C_O follow A_O/C_O.
- Registers: acc[7:0], cy, op[1:0], cnt[CNT_W:0]. Outputs A_O=ROT_X_O=acc, C_O=ROT_C_O=cy, ROT_OP_O=op.
- FSM states: IDLE, RUN, DONE.
- IDLE: DONE_O=0, BUSY_O=0.
  - START_I=1: load acc<=A_I, cy<=C_I, op<=OP_I, and cnt<=CNT_I, or 2**CNT_W if CNT_I=0. Go to RUN.
- RUN: BUSY_O=1.
  - Each cycle: acc<=ROT_E_I, cy<=ROT_C_I, cnt<=cnt-1.
  - When cnt==1, that step is the last; go to DONE.
  - START_I is ignored in RUN.
- DONE: DONE_O=1 for exactly one cycle, BUSY_O=0, acc/cy hold the result.
  - START_I=1 in DONE is accepted exactly as in IDLE (back-to-back); the next state is RUN.
  - Otherwise go to IDLE.
- Latency: START_I accepted at edge t; DONE_O is high in the cycle after edge t+N, i.e. N+1 cycles after acceptance. Throughput is one operation per N+1 cycles.
- acc/cy retain the last result in IDLE until the next accepted START.
- Z/S/P flags are not handled here; the rotator passes them through.
- Rotator result is sampled only in RUN; ROT_E_I/ROT_C_I are ignored in other states.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, and no DONE pulse is issued.
- Counter width is CNT_W+1 bits, so the 2**CNT_W count does not wrap.

Test Plan:
- Reset: RSTN_I=0 asynchronously mid-RUN -> immediately A_O=00, C_O=0, BUSY_O=0, DONE_O=0; after release the state is IDLE.
- Single step: A_I=81, C_I=0, CNT_I=1 gives, each result with DONE 2 cycles after START:
  - OP=00 -> A_O=03, C_O=1.
  - OP=01 -> A_O=C0, C_O=1.
  - OP=10 with A_I=80 -> A_O=00, C_O=1.
  - OP=11 with A_I=01 -> A_O=00, C_O=1.
- Full count: OP=00, A_I=A5, C_I=0, CNT_I=0 -> BUSY_O high 8 cycles, DONE at cycle 9, A_O=A5, C_O=1.
- 9-bit through-carry: OP=10, A_I=01, C_I=0, CNT_I=0 -> A_O=00, C_O=1. Also check intermediate A_O=80, C_O=0 after step 7.
- Handshake: pulse START_I again during RUN -> ignored, result unchanged. START_I held high during the DONE cycle -> new operation starts next cycle with no IDLE gap, and DONE_O is a single-cycle pulse per operation.
- Partial count: OP=01, A_I=F0, C_I=1, CNT_I=3 -> A_O=1E, C_O=0, DONE 4 cycles after START.
